// File: rtl/inport_capture_pkg.sv
// Shared sizing for the picoMIPS input-port front-end.
// Holds the default bus width, the debounce length and the counter-width helper.
package inport_capture_pkg;

    localparam int DATA_BUS_SIZE       = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Width needed for a counter that must be able to hold the value `cycles`.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/inport_capture_sync.sv
// Two-flop synchroniser for asynchronous inputs entering the clk domain.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of d; the first stage may go metastable.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/inport_capture.sv
// picoMIPS input port: synchronises switches and load button, debounces the button
// and latches the switch word once per clean press, flagging it valid until acked.
module inport_capture
    import inport_capture_pkg::*;
#(
    parameter int n               = DATA_BUS_SIZE,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [n-1:0] sw_in,
    input  logic         load_btn,
    input  logic         ack,
    output logic [n-1:0] inport,
    output logic         inport_valid
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    // The counter is compared before it increments, so the terminal test uses
    // DEBOUNCE_CYCLES-2: the transition edge is the one where cnt reaches DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESS   = 2'b01,
        HELD    = 2'b10,
        RELEASE = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             capture_s;
    logic [n-1:0]     inport_r;
    logic             valid_r;
    logic [n-1:0]     sw_s;
    logic             btn_s;

    sync_2ff #(.W(n)) u_sync_sw (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (sw_in),
        .q       (sw_s)
    );

    sync_2ff #(.W(1)) u_sync_btn (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (load_btn),
        .q       (btn_s)
    );

    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // Debounce next-state logic and capture strobe.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt = CNT_ZERO;
                if (btn_s) begin
                    state_nxt = PRESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PRESS: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt_r >= CNT_TERM) begin
                    state_nxt = HELD;
                    cnt_nxt   = CNT_ZERO;
                    capture_s = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc_s;
                end
            end
            HELD: begin
                cnt_nxt = CNT_ZERO;
                if (!btn_s) begin
                    state_nxt = RELEASE;
                end else begin
                    state_nxt = HELD;
                end
            end
            RELEASE: begin
                if (btn_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt_r >= CNT_TERM) begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt_inc_s;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers; a capture overrides a same-cycle ack.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            inport_r <= {n{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            if (capture_s) begin
                inport_r <= sw_s;
                valid_r  <= 1'b1;
            end else if (ack) begin
                valid_r  <= 1'b0;
            end else begin
                valid_r  <= valid_r;
            end
        end
    end

    assign inport       = inport_r;
    assign inport_valid = valid_r;

endmodule

// File: tb/tb_inport_capture.sv
// Directed bench for inport_capture with a run-length behavioural model and per-cycle compare.
module tb_inport_capture;

    localparam int N = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         n_reset;
    logic [N-1:0] sw_in;
    logic         load_btn;
    logic         ack;
    logic [N-1:0] inport;
    logic         inport_valid;

    int n_checks = 0;
    int n_fail   = 0;

    inport_capture #(.n(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .sw_in        (sw_in),
        .load_btn     (load_btn),
        .ack          (ack),
        .inport       (inport),
        .inport_valid (inport_valid)
    );

    always #5 clk = ~clk;

    // Model: a press is accepted after D consecutive high synchronised samples while armed;
    // re-arming needs D consecutive low samples. Synchroniser = two-sample delay.
    logic         p1 = 1'b0, p2 = 1'b0;
    logic [N-1:0] q1 = '0, q2 = '0;
    bit           armed = 1'b1;
    int           run_hi = 0, run_lo = 0;
    logic [N-1:0] m_inport = '0;
    logic         m_valid = 1'b0;

    always @(posedge clk or negedge n_reset) begin
        logic         b;
        logic [N-1:0] w;
        bit           cap;
        if (!n_reset) begin
            p1 = 1'b0; p2 = 1'b0; q1 = '0; q2 = '0;
            armed = 1'b1; run_hi = 0; run_lo = 0;
            m_inport = '0; m_valid = 1'b0;
        end else begin
            b = p2; w = q2;
            p2 = p1; p1 = load_btn;
            q2 = q1; q1 = sw_in;
            cap = 1'b0;
            if (armed) begin
                run_hi = b ? run_hi + 1 : 0;
                if (run_hi == D) begin
                    cap = 1'b1; armed = 1'b0; run_lo = 0;
                end
            end else begin
                run_lo = b ? 0 : run_lo + 1;
                if (run_lo == D) begin
                    armed = 1'b1; run_hi = 0;
                end
            end
            if (cap) begin
                m_inport = w; m_valid = 1'b1;
            end else if (ack) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (inport !== m_inport || inport_valid !== m_valid) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: inport=%h valid=%b, expected inport=%h valid=%b",
                     $time, inport, inport_valid, m_inport, m_valid);
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        n_reset = 1'b0; sw_in = 8'hFF; load_btn = 1'b1; ack = 1'b0;
        tick(4);
        check("reset_inport", inport, 8'h00);
        check("reset_valid", {7'd0, inport_valid}, 8'h00);
        load_btn = 1'b0; sw_in = 8'h00;
        tick(3);
        n_reset = 1'b1;
        tick(5);

        // Clean press: capture exactly on the 18th edge after the button edge.
        sw_in = 8'h5A; load_btn = 1'b1;
        tick(17);
        check("press_before_latency", {7'd0, inport_valid}, 8'h00);
        tick(1);
        check("press_valid", {7'd0, inport_valid}, 8'h01);
        check("press_word", inport, 8'h5A);
        sw_in = 8'h11;
        tick(22);
        check("held_no_repeat", inport, 8'h5A);
        load_btn = 1'b0;
        tick(20);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("ack_clear_1", {7'd0, inport_valid}, 8'h00);

        // Bounce: short pulses never qualify.
        sw_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            load_btn = 1'b1; tick(5);
            load_btn = 1'b0; tick(5);
        end
        tick(20);
        check("bounce_valid", {7'd0, inport_valid}, 8'h00);
        check("bounce_inport", inport, 8'h5A);

        // Ack after capture of 3C.
        sw_in = 8'h3C; load_btn = 1'b1;
        tick(20);
        check("cap3c_word", inport, 8'h3C);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("ack_valid", {7'd0, inport_valid}, 8'h00);
        check("ack_inport", inport, 8'h3C);
        load_btn = 1'b0;
        tick(20);

        // Collision: ack in the capture cycle.
        sw_in = 8'hA5; load_btn = 1'b1;
        tick(17);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("collide_valid", {7'd0, inport_valid}, 8'h01);
        check("collide_word", inport, 8'hA5);
        load_btn = 1'b0;
        tick(20);

        // Overwrite while valid (no ack in between).
        sw_in = 8'hC3; load_btn = 1'b1;
        tick(20);
        check("overwrite_word", inport, 8'hC3);
        check("overwrite_valid", {7'd0, inport_valid}, 8'h01);
        load_btn = 1'b0;
        tick(20);

        // Reset mid-PRESS (counter at 8), button still held afterwards.
        sw_in = 8'h77; load_btn = 1'b1;
        tick(11);
        n_reset = 1'b0;
        #1;
        check("midreset_valid", {7'd0, inport_valid}, 8'h00);
        check("midreset_inport", inport, 8'h00);
        tick(2);
        n_reset = 1'b1;
        tick(17);
        check("repress_before", {7'd0, inport_valid}, 8'h00);
        tick(1);
        check("repress_valid", {7'd0, inport_valid}, 8'h01);
        check("repress_word", inport, 8'h77);
        load_btn = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
